// File: rtl/dram_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dram_lsu_pkg : size encodings, FSM state type and lane-mask helper   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package dram_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SPLIT = 1'b1
   } lsu_state_t;

   // Lanes [3:0] belong to the addressed word, [7:4] spill into the next one.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
      logic [7:0] base;
      case (size)
         SZ_BYTE: base = 8'h01;
         SZ_HALF: base = 8'h03;
         SZ_WORD: base = 8'h0F;
         default: base = 8'h00;
      endcase
      return base << offset;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_load_align : byte/half/word select and sign/zero extension       |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module lsu_load_align
   import dram_lsu_pkg::*;
(
   input  logic [63:0] data,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [31:0] w_shifted;

   assign w_shifted = 32'(data >> {offset, 3'b000});

   always_comb begin
      case (size)
         SZ_BYTE: result = {{24{~is_unsigned & w_shifted[7]}},  w_shifted[7:0]};
         SZ_HALF: result = {{16{~is_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         default: result = w_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dram_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dram_lsu : byte/half/word load-store bridge onto data RAM port B     |
// | Option   : MISALIGN_SPLIT_EN splits misaligned half/word accesses    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dram_lsu
   import dram_lsu_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_wem,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
);

   logic              w_accept;
   logic              w_aligned;
   logic              w_split;
   logic              w_err;
   logic [1:0]        w_off;
   logic [ADDR_W-1:0] w_word;
   logic [7:0]        w_mask;
   logic [31:0]       w_rep;
   logic [31:0]       w_din;
   logic [63:0]       w_align_in;
   logic [31:0]       w_load_data;
   logic              unused_addr_hi;

   logic [1:0]        r_off;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic              r_load;

`ifdef MISALIGN_SPLIT_EN
   lsu_state_t        r_state;
   logic              r_ready;
   logic              r_we;
   logic              r_split;
   logic [31:0]       r_dout1;
   logic [ADDR_W-1:0] r_addr2;
   logic [3:0]        r_wem2;
   logic [31:0]       r_din2;
`else
   logic [3:0]        unused_mask_hi;
`endif

   assign w_off          = req_addr[1:0];
   assign w_word         = req_addr[ADDR_W+1:2];
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
   assign w_mask         = lane_mask(req_size, w_off);
   assign w_accept       = req_valid & req_ready;

   always_comb begin
      case (req_size)
         SZ_BYTE: w_aligned = 1'b1;
         SZ_HALF: w_aligned = ~w_off[0];
         SZ_WORD: w_aligned = (w_off == 2'b00);
         default: w_aligned = 1'b0;
      endcase
   end

   always_comb begin
      case (req_size)
         SZ_BYTE: w_rep = {4{req_wdata[7:0]}};
         SZ_HALF: w_rep = {2{req_wdata[15:0]}};
         default: w_rep = req_wdata;
      endcase
   end

`ifdef MISALIGN_SPLIT_EN
   assign w_split   = (req_size != SZ_BAD) & ~w_aligned;
   assign req_ready = r_ready;

   // Rotating the replicated data puts every byte on its own lane in both accesses.
   always_comb begin
      case (w_off)
         2'd0:    w_din = w_rep;
         2'd1:    w_din = {w_rep[23:0], w_rep[31:24]};
         2'd2:    w_din = {w_rep[15:0], w_rep[31:16]};
         default: w_din = {w_rep[7:0],  w_rep[31:8]};
      endcase
   end

   assign w_align_in = r_split ? {ram_dout, r_dout1} : {32'h0, ram_dout};
`else
   assign w_split        = 1'b0;
   assign req_ready      = 1'b1;
   assign w_din          = w_rep;
   assign w_align_in     = {32'h0, ram_dout};
   assign unused_mask_hi = w_mask[7:4];
`endif

   assign w_err = ~w_aligned & ~w_split;

   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_wem  = 4'h0;
      ram_din  = 32'h0;
`ifdef MISALIGN_SPLIT_EN
      if (r_state == ST_SPLIT) begin
         ram_en   = 1'b1;
         ram_we   = r_we;
         ram_addr = r_addr2;
         if (r_we) begin
            ram_wem = r_wem2;
            ram_din = r_din2;
         end
      end else
`endif
      if (w_accept & ~w_err) begin
         ram_en   = 1'b1;
         ram_we   = req_we;
         ram_addr = w_word;
         if (req_we) begin
            ram_wem = w_mask[3:0];
            ram_din = w_din;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         r_load     <= 1'b0;
         r_off      <= 2'b00;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
         r_state    <= ST_IDLE;
         r_ready    <= 1'b1;
         r_we       <= 1'b0;
         r_split    <= 1'b0;
         r_dout1    <= 32'h0;
         r_addr2    <= '0;
         r_wem2     <= 4'h0;
         r_din2     <= 32'h0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         r_load    <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
         r_split   <= 1'b0;
         if (r_state == ST_SPLIT) begin
            // First-half read data is on ram_dout now; the second half arrives next cycle.
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_dout1   <= ram_dout;
            r_split   <= 1'b1;
            rsp_valid <= 1'b1;
            r_load    <= ~r_we;
         end else
`endif
         if (w_accept) begin
            r_off      <= w_off;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
`ifdef MISALIGN_SPLIT_EN
            r_we       <= req_we;
            if (w_split) begin
               r_state <= ST_SPLIT;
               r_ready <= 1'b0;
               r_addr2 <= w_word + 1'b1;
               r_wem2  <= w_mask[7:4];
               r_din2  <= w_din;
            end else
`endif
            begin
               rsp_valid <= 1'b1;
               rsp_err   <= w_err;
               r_load    <= ~req_we & ~w_err;
            end
         end
      end
   end

   lsu_load_align u_load_align (
      .data        (w_align_in),
      .offset      (r_off),
      .size        (r_size),
      .is_unsigned (r_unsigned),
      .result      (w_load_data)
   );

   assign rsp_rdata = r_load ? w_load_data : 32'h0;

endmodule
`default_nettype wire
